// File: rtl/cxu_li_responder.sv
// -----------------------------------------------------------------------------
// cxu_li_responder
//
// This is the responder end of the CXU-LI link. It takes one flow-controlled
// request, computes a result and returns it as a flow-controlled response.
//
// Functions selected by req_func_id:
//   0 = add  (data0 + data1, wraps)
//   1 = sub  (data0 - data1, wraps)
//   2 = popcount(data0), zero-extended
//   3 = mul-low, computed over CXU_DATA_W cycles by an iterative shift-add
//   Any other id returns ERROR status with zero data.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     request valid (initiator -> responder)
//   req_ready     responder can accept a request
//   req_func_id   function selector, CXU_FUNC_ID_W bits
//   req_data0     operand A
//   req_data1     operand B
//   resp_valid    response valid (responder -> initiator)
//   resp_ready    initiator accepts the response
//   resp_status   0 = OK, 1 = ERROR
//   resp_data     result
//
// Only one request is in flight at a time. The response register holds the
// result until it is taken, so initiator backpressure never stalls the
// arithmetic mid-operation.
// -----------------------------------------------------------------------------
module cxu_li_responder #(
    parameter int CXU_FUNC_ID_W = 10,
    parameter int CXU_DATA_W    = 32,
    parameter int CXU_STATUS_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [CXU_FUNC_ID_W-1:0] req_func_id,
    input  logic [CXU_DATA_W-1:0]    req_data0,
    input  logic [CXU_DATA_W-1:0]    req_data1,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [CXU_STATUS_W-1:0]  resp_status,
    output logic [CXU_DATA_W-1:0]    resp_data
);

    localparam int CNT_W = $clog2(CXU_DATA_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;

    logic [CXU_DATA_W-1:0]   mul_a_reg;
    logic [CXU_DATA_W-1:0]   mul_b_reg;
    logic [CXU_DATA_W-1:0]   acc_reg;
    logic [CNT_W-1:0]        cnt_reg;

    logic                    req_hs;
    logic                    resp_hs;
    logic                    mul_done;

    logic [CXU_DATA_W-1:0]   pop_count;
    logic [CXU_DATA_W-1:0]   op_data;
    logic [CXU_STATUS_W-1:0] op_status;

    logic                    load_resp;
    logic [CXU_DATA_W-1:0]   load_data;
    logic [CXU_STATUS_W-1:0] load_status;
    logic                    start_mul;

    // The response slot is free when it is empty or is being emptied this
    // cycle. This lets a new request load in the same cycle the old response
    // retires. rst_n gates the signal so that req_ready stays low during reset.
    assign req_ready = rst_n && (state_reg == IDLE) && (!resp_valid || resp_ready);
    assign req_hs    = req_valid && req_ready;
    assign resp_hs   = resp_valid && resp_ready;
    assign mul_done  = (cnt_reg == CNT_W'(CXU_DATA_W));

    // Single-cycle result datapath
    always_comb begin
        pop_count = '0;
        for (int i = 0; i < CXU_DATA_W; i++) begin
            pop_count = pop_count + CXU_DATA_W'(req_data0[i]);
        end

        op_data   = '0;
        op_status = '0;
        if (req_func_id == CXU_FUNC_ID_W'(0)) begin
            op_data = req_data0 + req_data1;
        end else if (req_func_id == CXU_FUNC_ID_W'(1)) begin
            op_data = req_data0 - req_data1;
        end else if (req_func_id == CXU_FUNC_ID_W'(2)) begin
            op_data = pop_count;
        end else begin
            // An invalid id reports ERROR with zero data. Function 3 never
            // takes this path because the FSM sends it to BUSY.
            op_status = CXU_STATUS_W'(1);
        end
    end

    // FSM next state and load controls
    always_comb begin
        state_next  = state_reg;
        load_resp   = 1'b0;
        load_data   = '0;
        load_status = '0;
        start_mul   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_hs) begin
                    if (req_func_id == CXU_FUNC_ID_W'(3)) begin
                        start_mul  = 1'b1;
                        state_next = BUSY;
                    end else begin
                        load_resp   = 1'b1;
                        load_data   = op_data;
                        load_status = op_status;
                    end
                end
            end
            BUSY: begin
                // The response slot is always empty while in BUSY, because
                // the request was only accepted when the slot was freeing.
                // The product can therefore load without checking resp_ready.
                if (mul_done) begin
                    load_resp   = 1'b1;
                    load_data   = acc_reg;
                    load_status = '0;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Iterative shift-add multiplier. Each BUSY cycle performs one step. After
    // CXU_DATA_W steps, the next cycle loads the product into the response.
    // The response therefore appears CXU_DATA_W+1 cycles after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_reg <= '0;
            mul_b_reg <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (start_mul) begin
            mul_a_reg <= req_data0;
            mul_b_reg <= req_data1;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if ((state_reg == BUSY) && !mul_done) begin
            if (mul_b_reg[0]) begin
                acc_reg <= acc_reg + mul_a_reg;
            end
            mul_a_reg <= mul_a_reg << 1;
            mul_b_reg <= mul_b_reg >> 1;
            cnt_reg   <= cnt_reg + CNT_W'(1);
        end
    end

    // Response register. A load takes priority over a retire, so a response
    // that retires and reloads at the same edge keeps resp_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_status <= '0;
        end else if (load_resp) begin
            resp_valid  <= 1'b1;
            resp_data   <= load_data;
            resp_status <= load_status;
        end else if (resp_hs) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule
